// File: rtl/mult_pkg.sv
// Shared constants and the pipeline token for the parameterised array multiplier.
// Operand fields are sized for the widest legal WIDTH; narrower builds use the low bits.
package mult_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;
    localparam int DEF_ACC_W  = 2 * DEF_WIDTH + 4;
    localparam int MAX_WIDTH  = 16;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic                 is_signed;
        logic                 acc_en;
        logic                 acc_clr;
        logic                 valid;
    } token_t;

endpackage

// File: rtl/array_mult_row.sv
// One carry-save row of the array multiplier: adds partial-product row ROW (a * b[ROW])
// into a redundant sum/carry pair, with Baugh-Wooley bit inversion in signed mode.
module array_mult_row
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ROW   = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  logic               b_bit,
    input  logic               is_signed,
    input  logic               corr,
    input  logic [2*WIDTH-1:0] sum_in,
    input  logic [2*WIDTH-1:0] carry_in,
    output logic [2*WIDTH-1:0] sum_out,
    output logic [2*WIDTH-1:0] carry_out
);

    localparam int P = 2 * WIDTH;

    logic [P-1:0] pp;
    logic [P-2:0] maj;

    always_comb begin
        // NOTE: default every bit first so no path through the block leaves pp unassigned (latch).
        pp = '0;
        for (int j = 0; j < WIDTH; j++) begin
            // Terms with exactly one sign-bit operand are complemented in signed mode.
            pp[ROW + j] = (a[j] & b_bit) ^ (is_signed && ((ROW == WIDTH - 1) != (j == WIDTH - 1)));
        end
        // Correction constant 2^W + 2^(2W-1); only row 0 drives it, where those bits are free.
        if (corr) begin
            pp[WIDTH] = 1'b1;
            pp[P-1]   = 1'b1;
        end
    end

    assign maj       = (sum_in[P-2:0] & carry_in[P-2:0]) | (sum_in[P-2:0] & pp[P-2:0])
                     | (carry_in[P-2:0] & pp[P-2:0]);
    assign sum_out   = sum_in ^ carry_in ^ pp;
    assign carry_out = {maj, 1'b0};

endmodule

// File: rtl/param_array_mult.sv
// Pipelined signed/unsigned array multiplier with valid/ready handshake and a
// signed wrap-around accumulator with sticky overflow.
module param_array_mult
    import mult_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int ACC_W  = 2 * WIDTH + 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [ACC_W-1:0]   acc,
    output logic               acc_ovf
);

    localparam int P    = 2 * WIDTH;
    localparam int RPS  = WIDTH / STAGES;
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

    token_t       in_tok;
    token_t       tok_d [STAGES];
    token_t       tok_q [STAGES];
    logic [P-1:0] sum_d [NREG];
    logic [P-1:0] car_d [NREG];
    logic [P-1:0] sum_q [NREG];
    logic [P-1:0] car_q [NREG];
    logic [P-1:0] product_d;
    logic [P-1:0] product_q;
    logic         stall;
    logic         advance;

    // A full output slot that is not being taken freezes the entire pipeline.
    assign out_valid = tok_q[STAGES-1].valid;
    assign stall     = out_valid && !out_ready;
    assign advance   = !stall;
    assign in_ready  = !stall;

    always_comb begin
        in_tok              = '0;
        in_tok.a[WIDTH-1:0] = a;
        in_tok.b[WIDTH-1:0] = b;
        in_tok.is_signed    = is_signed;
        in_tok.acc_en       = acc_en;
        in_tok.acc_clr      = acc_clr;
        in_tok.valid        = in_valid;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        token_t       st_tok;
        logic [P-1:0] ch_sum [RPS+1];
        logic [P-1:0] ch_car [RPS+1];

        if (s == 0) begin : g_first
            assign st_tok    = in_tok;
            assign ch_sum[0] = '0;
            assign ch_car[0] = '0;
        end else begin : g_next
            assign st_tok    = tok_q[s-1];
            assign ch_sum[0] = sum_q[s-1];
            assign ch_car[0] = car_q[s-1];
        end

        for (genvar r = 0; r < RPS; r++) begin : g_row
            localparam int ROW = s * RPS + r;
            array_mult_row #(
                .WIDTH(WIDTH),
                .ROW  (ROW)
            ) u_row (
                .a        (st_tok.a[WIDTH-1:0]),
                .b_bit    (st_tok.b[ROW]),
                .is_signed(st_tok.is_signed),
                .corr     ((ROW == 0) && st_tok.is_signed),
                .sum_in   (ch_sum[r]),
                .carry_in (ch_car[r]),
                .sum_out  (ch_sum[r+1]),
                .carry_out(ch_car[r+1])
            );
        end

        assign tok_d[s] = st_tok;

        if (s == STAGES - 1) begin : g_cpa
            assign product_d = ch_sum[RPS] + ch_car[RPS];
        end else begin : g_pass
            assign sum_d[s] = ch_sum[RPS];
            assign car_d[s] = ch_car[RPS];
        end
    end

    if (STAGES == 1) begin : g_noreg
        logic unused_pipe;
        assign sum_d[0]    = '0;
        assign car_d[0]    = '0;
        assign unused_pipe = ^{sum_q[0], car_q[0]};
    end

    // Operand bits above WIDTH and the operands of the output token are never read.
    logic [STAGES-1:0] unused_tok;
    for (genvar s = 0; s < STAGES; s++) begin : g_unused
        assign unused_tok[s] = ^tok_q[s];
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too, so product reads 0 and no stale data survives reset.
        if (rst) begin
            for (int s = 0; s < STAGES; s++) tok_q[s] <= '0;
            for (int s = 0; s < NREG; s++) begin
                sum_q[s] <= '0;
                car_q[s] <= '0;
            end
            product_q <= '0;
        end else if (advance) begin
            // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
            for (int s = 0; s < STAGES; s++) tok_q[s] <= tok_d[s];
            for (int s = 0; s < NREG; s++) begin
                sum_q[s] <= sum_d[s];
                car_q[s] <= car_d[s];
            end
            product_q <= product_d;
        end
    end

    assign product = product_q;

    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_sum;
    logic             add_ovf;
    logic             out_xfer;

    assign out_xfer = out_valid && out_ready;

    always_comb begin
        addend   = tok_q[STAGES-1].is_signed ? ACC_W'($signed(product_q)) : ACC_W'(product_q);
        acc_base = tok_q[STAGES-1].acc_clr ? '0 : acc_q;
        acc_sum  = acc_base + addend;
        add_ovf  = (acc_base[ACC_W-1] == addend[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (out_xfer) begin
            if (tok_q[STAGES-1].acc_clr) begin
                acc_q <= acc_sum;
                ovf_q <= add_ovf;
            end else if (tok_q[STAGES-1].acc_en) begin
                acc_q <= acc_sum;
                ovf_q <= ovf_q | add_ovf;
            end
        end
    end

    assign acc     = acc_q;
    assign acc_ovf = ovf_q;

endmodule

// File: tb/tb_param_array_mult.sv
// Directed bench for param_array_mult at WIDTH=8, STAGES=2, ACC_W=20: latency, signed and
// unsigned products, stall/backpressure ordering, accumulator wrap/overflow and mid-run reset.
module tb_param_array_mult;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int ACC_W  = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic               is_signed = 1'b0;
    logic               acc_en = 1'b0;
    logic               acc_clr = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2*WIDTH-1:0] product;
    logic [ACC_W-1:0]   acc;
    logic               acc_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    param_array_mult #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .acc      (acc),
        .acc_ovf  (acc_ovf)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic        en;
        logic        clr;
        logic [15:0] prod;
        logic [19:0] acc;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One token with out_ready high: result must appear exactly two cycles after the transfer.
    task automatic send(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic sgn, input logic en, input logic clr,
                        input logic [15:0] ep, input logic [19:0] eacc, input logic eovf);
        a = ta; b = tb; is_signed = sgn; acc_en = en; acc_clr = clr; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " out_valid@1"}, out_valid, 1'b0);
        @(posedge clk); #1;
        check({tag, " out_valid@2"}, out_valid, 1'b1);
        check({tag, " product"}, product, ep);
        @(posedge clk); #1;
        check({tag, " out_valid@3"}, out_valid, 1'b0);
        check({tag, " acc"}, acc, eacc);
        check({tag, " acc_ovf"}, acc_ovf, eovf);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] stall_exp [4];
        int          sent;
        int          recv;
        int          k_acc;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 16'hFE01, 20'h0FE01, 1'b0};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 1'b0, 1'b1, 16'h4000, 20'h04000, 1'b0};
        vecs[2] = '{8'hFF, 8'h03, 1'b1, 1'b1, 1'b0, 16'hFFFD, 20'h03FFD, 1'b0};
        vecs[3] = '{8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 16'h2710, 20'h02710, 1'b0};
        vecs[4] = '{8'd200, 8'd200, 1'b0, 1'b1, 1'b0, 16'h9C40, 20'h0C350, 1'b0};
        vecs[5] = '{8'd7,   8'd9,   1'b0, 1'b0, 1'b0, 16'h003F, 20'h0C350, 1'b0};
        vecs[6] = '{8'h85, 8'h7F, 1'b1, 1'b1, 1'b0, 16'hC2FB, 20'h0864B, 1'b0};
        vecs[7] = '{8'h00, 8'hAB, 1'b0, 1'b1, 1'b0, 16'h0000, 20'h0864B, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 16'hC080, 20'hFC080, 1'b0};
        vecs[9] = '{8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0, 16'h00E1, 20'hFC161, 1'b0};

        // Reset state
        #3;
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst product", product, 16'h0000);
        check("rst acc", acc, 20'h00000);
        check("rst acc_ovf", acc_ovf, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single tokens
        for (int i = 0; i < 10; i++) begin
            send($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].en,
                 vecs[i].clr, vecs[i].prod, vecs[i].acc, vecs[i].ovf);
        end

        // Four back-to-back tokens, out_ready low in cycles 3..5
        stall_exp[0] = 16'd10; stall_exp[1] = 16'd22; stall_exp[2] = 16'd36; stall_exp[3] = 16'd52;
        sent = 0;
        recv = 0;
        is_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        for (int n = 0; n < 14; n++) begin
            out_ready = !(n >= 3 && n <= 5);
            in_valid  = (sent < 4);
            a = 8'(sent + 1);
            b = 8'(sent + 10);
            #1;
            check($sformatf("stall in_ready cyc%0d", n), in_ready, (n >= 3 && n <= 5) ? 1'b0 : 1'b1);
            if (n >= 3 && n <= 5) begin
                check($sformatf("stall hold product cyc%0d", n), product, stall_exp[1]);
            end
            if (out_valid && out_ready) begin
                if (recv < 4) begin
                    check($sformatf("stall product #%0d", recv), product, stall_exp[recv]);
                end else begin
                    check("stall duplicate output", 32'(recv), 32'd4);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall tokens received", 32'(recv), 32'd4);
        check("stall acc untouched", acc, 20'hFC161);

        // Signed accumulate of 127*127 until wrap into the sign bit
        for (int k = 1; k <= 34; k++) begin
            k_acc = k * 16129;
            send($sformatf("ovf%0d", k), 8'h7F, 8'h7F, 1'b1, (k != 1), (k == 1), 16'h3F01,
                 20'(k_acc), (k_acc > 524287));
        end
        send("ovf hold", 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 16'h0004, 20'h85E22, 1'b1);
        send("ovf clear", 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 16'h0001, 20'h00001, 1'b0);

        // Reset with two tokens in flight
        a = 8'd1; b = 8'd2; is_signed = 1'b0; acc_en = 1'b1; acc_clr = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 8'd3; b = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight out_valid before rst", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst product", product, 16'h0000);
        check("midrst acc", acc, 20'h00000);
        check("midrst in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send("post rst first", 8'd3, 8'd5, 1'b0, 1'b0, 1'b1, 16'h000F, 20'h0000F, 1'b0);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            check($sformatf("post rst idle out_valid %0d", n), out_valid, 1'b0);
            check($sformatf("post rst idle acc %0d", n), acc, 20'h0000F);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
